// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC and PRId registers, plus exception/interrupt
// acceptance for the M stage.
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_4849
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic [4:0]  exccode,
  input  logic        bd,
  input  logic [5:0]  hwint,
  input  logic        exl_clr,
  output logic        intreq,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd_r;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc_r;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] victim_pc;

  always_comb begin
    int_pend  = (|(hwint & im)) & ie & ~exl;
    exc_pend  = (exccode != 5'd0) & ~exl;
    intreq    = (int_pend | exc_pend) & ~reset;
    victim_pc = {pc[31:2], 2'b00} - (bd ? 32'd4 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd_r     <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc_r    <= '0;
    end else begin
      ip <= hwint;
      if (intreq) begin
        exl      <= 1'b1;
        bd_r     <= bd;
        epc_r    <= victim_pc;
        exc_code <= int_pend ? 5'd0 : exccode;
      end else begin
        if (we) begin
          if (a2 == 5'd12) begin
            im  <= din[15:10];
            exl <= din[1];
            ie  <= din[0];
          end else if (a2 == 5'd14) begin
            epc_r <= {din[31:2], 2'b00};
          end
        end
        // Placed after the SR write so eret wins the EXL bit when both fire.
        if (exl_clr) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    epc = epc_r;
    case (a1)
      5'd12:   dout = {16'b0, im, 8'b0, exl, ie};
      5'd13:   dout = {bd_r, 15'b0, ip, 3'b0, exc_code, 2'b00};
      5'd14:   dout = epc_r;
      5'd15:   dout = PRID;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios with literal expectations,
// then randomized traffic against a register-word reference model.
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2;
  logic [31:0] din, pc;
  logic        we, bd, exl_clr;
  logic [4:0]  exccode;
  logic [5:0]  hwint;
  logic        intreq;
  logic [31:0] epc, dout;

  int checks = 0;
  int errors = 0;

  cp0 #(.PRID(32'h0000_4849)) dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din), .we(we),
    .pc(pc), .exccode(exccode), .bd(bd), .hwint(hwint), .exl_clr(exl_clr),
    .intreq(intreq), .epc(epc), .dout(dout)
  );

  always #5 clk = ~clk;

  // Reference model: whole register words, fields located by bit position.
  logic [31:0] m_sr, m_cause, m_epc;
  logic        m_valid = 1'b0;

  function automatic logic m_int();
    return ((hwint & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc();
    return (exccode != 5'd0) && !m_sr[1];
  endfunction

  function automatic logic m_intreq();
    return !reset && (m_int() || m_exc());
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    case (idx)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4849;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_intreq()) begin
        m_cause = (32'(bd) << 31) | (32'(hwint) << 10)
                | (32'(m_int() ? 5'd0 : exccode) << 2);
        m_epc   = (pc & ~32'h3) - (bd ? 32'd4 : 32'd0);
        m_sr    = m_sr | 32'h2;
      end else begin
        if (we && a2 == 5'd12) m_sr  = din & 32'h0000_FC03;
        if (we && a2 == 5'd14) m_epc = din & ~32'h3;
        if (exl_clr)           m_sr  = m_sr & ~32'h2;
        m_cause = (m_cause & ~32'h0000_FC00) | (32'(hwint) << 10);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("intreq", {31'd0, intreq}, {31'd0, m_intreq()});
      chk("epc", epc, m_epc);
      chk("dout", dout, m_read(a1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; a2 = 5'd0; din = 32'd0; exl_clr = 1'b0;
    exccode = 5'd0; bd = 1'b0; pc = 32'd0;
  endtask

  initial begin
    reset = 1'b1; a1 = 5'd12; hwint = 6'd0;
    idle();
    exccode = 5'd4; hwint = 6'h3f;
    cyc();
    cyc();
    reset = 1'b0; idle(); hwint = 6'd0;
    #2 chk("reset_sr", dout, 32'd0);
    a1 = 5'd15;
    #0 chk("prid", dout, 32'h0000_4849);

    // Address error on load, not in a delay slot.
    exccode = 5'd4; pc = 32'h3010;
    #1 chk("exc_intreq", {31'd0, intreq}, 32'd1);
    cyc(); idle(); a1 = 5'd14;
    #1 chk("exc_epc", dout, 32'h3010);
    a1 = 5'd13;
    #1 chk("exc_cause", dout, 32'h0000_0010);
    a1 = 5'd12;
    #1 chk("exc_exl", dout, 32'h0000_0002);

    exl_clr = 1'b1;
    cyc(); idle();
    // Delay-slot victim: EPC points at the branch.
    exccode = 5'd5; pc = 32'h3024; bd = 1'b1;
    cyc(); idle(); a1 = 5'd14;
    #1 chk("bd_epc", epc, 32'h3020);
    a1 = 5'd13;
    #1 chk("bd_cause", dout, 32'h8000_0014);

    exl_clr = 1'b1;
    cyc(); idle();
    we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
    cyc(); idle();
    hwint = 6'b000001; exccode = 5'd10; pc = 32'h4000;
    #1 chk("int_intreq", {31'd0, intreq}, 32'd1);
    cyc(); idle(); exccode = 5'd12; pc = 32'h4004;
    #1 chk("masked_intreq", {31'd0, intreq}, 32'd0);
    a1 = 5'd13;
    #1 chk("int_cause", dout, 32'h0000_0400);
    cyc(); idle(); a1 = 5'd14;
    #1 chk("held_epc", dout, 32'h4000);

    // IM cleared while EXL is still set, then eret with hwint still high.
    we = 1'b1; a2 = 5'd12; din = 32'h0000_0003;
    cyc(); idle(); exl_clr = 1'b1;
    cyc(); idle(); a1 = 5'd12;
    #1 chk("eret_sr", dout, 32'h0000_0001);
    chk("eret_intreq", {31'd0, intreq}, 32'd0);
    we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
    cyc(); idle();
    #1 chk("im_intreq", {31'd0, intreq}, 32'd1);
    cyc(); idle(); hwint = 6'd0; exl_clr = 1'b1;

    // EPC write colliding with an exception is dropped.
    cyc(); idle();
    we = 1'b1; a2 = 5'd14; din = 32'h3003; exccode = 5'd4; pc = 32'h5008;
    cyc(); idle();
    #1 chk("collide_epc", epc, 32'h5008);
    exl_clr = 1'b1;
    cyc(); idle();
    we = 1'b1; a2 = 5'd14; din = 32'h3003;
    cyc(); idle(); a1 = 5'd14;
    #1 chk("write_epc", dout, 32'h3000);

    // SR write and eret together: EXL ends up clear.
    we = 1'b1; a2 = 5'd12; din = 32'h0000_0002; exl_clr = 1'b1;
    cyc(); idle(); a1 = 5'd12;
    #1 chk("we_eret_sr", dout, 32'h0);

    for (int unsigned i = 0; i < 3000; i++) begin
      logic [4:0] codes [7];
      codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
      reset   = ($urandom_range(0, 99) < 2);
      exccode = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 6)] : 5'd0;
      hwint   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      pc      = $urandom;
      bd      = 1'($urandom);
      we      = ($urandom_range(0, 9) < 3);
      a2      = ($urandom_range(0, 1) == 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      din     = $urandom;
      exl_clr = ($urandom_range(0, 4) == 0);
      a1      = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 Parameter PRID, default 32'h0000_4849, constant value returned when register 15 is read.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a1  input  5  read register index; 12=SR, 13=Cause, 14=EPC, 15=PRId.
REQ-005 a2  input  5  write register index for mtc0.
REQ-006 din  input  32  mtc0 write data.
REQ-007 we  input  1  mtc0 write enable from the M stage.
REQ-008 pc  input  32  PC of the instruction in the M stage (victim PC).
REQ-009 exccode  input  5  M-stage exception code; 0 = none, 4 = AdEL, 5 = AdES, 10 = RI, 12 = Ov.
REQ-010 bd  input  1  M-stage instruction sits in a branch delay slot.
REQ-011 hwint  input  6  external interrupt lines, level-sensitive.
REQ-012 exl_clr  input  1  eret is in the M stage.
REQ-013 intreq  output  1  exception or interrupt accepted this cycle; pipeline flushes and fetches from the handler.
REQ-014 epc  output  32  current EPC register value.
REQ-015 dout  output  32  combinational read data selected by a1.

Function
REQ-016 SR fields SHALL be IM[15:10], EXL[1], IE[0]; all other SR bits read 0.
REQ-017 Cause fields SHALL be BD[31], IP[15:10], ExcCode[6:2]; all other Cause bits read 0.
REQ-018 int_pend SHALL equal |(hwint & IM) & IE & !EXL.
REQ-019 exc_pend SHALL equal (exccode != 0) & !EXL.
REQ-020 intreq SHALL equal int_pend | exc_pend, combinationally, in the same cycle.
REQ-021 On a clock edge with intreq=1: EXL<=1 and Cause.BD<=bd.
REQ-022 On the same edge, EPC SHALL load {pc[31:2],2'b00}-4 when bd=1, else {pc[31:2],2'b00}.
REQ-023 On the same edge, ExcCode SHALL load 0 when int_pend=1, else exccode; interrupt has priority over exception.
REQ-024 Cause.IP SHALL load hwint on every non-reset edge, independent of EXL and IE.
REQ-025 Edge with exl_clr=1 and intreq=0: EXL<=0; no other register changes.
REQ-026 Edge with we=1 and intreq=0: a2=12 writes IM, EXL, IE from din; a2=14 writes EPC with {din[31:2],2'b00}.
REQ-027 Writes to Cause, PRId or any other index SHALL be ignored.
REQ-028 intreq=1 in the same cycle as we or exl_clr: the write and eret SHALL be discarded; exception/interrupt update only.
REQ-029 we=1 and exl_clr=1 together without intreq: both SHALL take effect, and eret clears EXL after the SR write.
REQ-030 dout SHALL be 0 for indices other than 12–15 and SHALL show register state from before the current edge (no write-through).
REQ-031 While EXL=1, further exceptions and interrupts SHALL be masked: intreq=0 and registers hold, except Cause.IP and writes.
REQ-032 epc output SHALL reflect the EPC register; a value updated at an edge is visible in the next cycle.

Reset
REQ-033 On a reset edge: SR=0, ExcCode=0, BD=0, IP=0, EPC=0.
REQ-034 During a reset cycle, intreq SHALL be 0 regardless of exccode or hwint.
REQ-035 reset SHALL override intreq, we and exl_clr in the same cycle.

Verification
REQ-036 Reset, then exccode=4, pc=32'h3010, bd=0 -> intreq=1 that cycle; next cycle EPC=32'h3010, ExcCode=4, EXL=1, BD=0.
REQ-037 exccode=5, pc=32'h3024, bd=1 -> EPC=32'h3020, BD=1, ExcCode=5.
REQ-038 mtc0 SR=32'h0000_0401, then hwint=6'b000001 with exccode=10 together -> intreq=1, ExcCode=0, EXL=1; a second exccode=12 next cycle -> intreq=0, state held.
REQ-039 With EXL=1, exl_clr=1 and pending hwint masked by IM -> EXL=0 next cycle, intreq stays 0; then set IM bit -> intreq=1.
REQ-040 we=1, a2=14, din=32'h3003 in the same cycle as exccode=4 -> write discarded, EPC=pc; a later isolated write -> EPC=32'h3000, read via a1=14.
